// File: rtl/four_bit_seq_divider.sv
// +-----------------------------------------------------------------------+
// | four_bit_seq_divider: restoring unsigned divider, one bit per clock   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module four_bit_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_p;
    logic [WIDTH+1:0] w_sum;
    logic             w_take;

    assign w_p   = {rem_q, dvd_q[WIDTH-1]};
    assign w_sum = {1'b0, w_p} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
    // Top bit is the carry-out; when it is set, bit WIDTH of T is always zero.
    assign w_take = w_sum[WIDTH+1] & ~w_sum[WIDTH];

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d = A;
                    dvs_d = B;
                    cnt_d = '0;
                    if (B == '0) begin
                        quo_d   = '1;
                        rem_d   = A;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = '0;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = w_take ? w_sum[WIDTH-1:0] : w_p[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], w_take};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign Q           = quo_q;
    assign R           = rem_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
